// File: rtl/barrel_shifter_pipelined_if.sv
// Valid/ready stream bundle for the pipelined barrel shifter.
// Operand side flows in, result side flows out.
interface barrel_shifter_pipelined_if #(
    parameter int WIDTH = 8
);
    localparam int SHIFT_WIDTH = $clog2(WIDTH);

    logic [WIDTH-1:0]       data_in;
    logic [SHIFT_WIDTH-1:0] shift_in;
    logic [1:0]             mode_in;
    logic                   valid_in;
    logic                   ready_in;
    logic [WIDTH-1:0]       data_out;
    logic                   valid_out;
    logic                   ready_out;

    modport master (
        output data_in, shift_in, mode_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );

    modport slave (
        input  data_in, shift_in, mode_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );
endinterface

// File: rtl/barrel_shifter_pipelined.sv
// Run-time shift/rotate split over STAGES registered steps,
// each stage applying its own slice of the amount bits.
module barrel_shifter_pipelined #(
    parameter int   WIDTH     = 8,
    parameter int   STAGES    = 3,
    parameter logic PAD_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    barrel_shifter_pipelined_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int G  = (SW + STAGES - 1) / STAGES;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } mode_e;

    function automatic logic [SW-1:0] grp_mask(input int s);
        logic [SW-1:0] m;
        m = '0;
        for (int b = 0; b < SW; b++) begin
            if (b >= s * G && b < (s + 1) * G) m[b] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] shift_op(
        input logic [WIDTH-1:0] d,
        input logic [SW-1:0]    n,
        input mode_e            m,
        input logic             sgn
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        r    = d;
        unique case (m)
            LSL: r = (d << n) | ({WIDTH{PAD_VALUE}} & ~(ones << n));
            LSR: r = (d >> n) | ({WIDTH{PAD_VALUE}} & ~(ones >> n));
            ASR: r = (d >> n) | ({WIDTH{sgn}} & ~(ones >> n));
            ROL: r = (d << n) | (d >> (WIDTH - int'(n)));
        endcase
        return r;
    endfunction

    logic             valid_q [STAGES];
    logic [WIDTH-1:0] data_q  [STAGES];
    logic [SW-1:0]    amt_q   [STAGES];
    mode_e            mode_q  [STAGES];
    logic             sign_q  [STAGES];

    logic             valid_d [STAGES];
    logic [WIDTH-1:0] data_d  [STAGES];
    logic [SW-1:0]    amt_d   [STAGES];
    mode_e            mode_d  [STAGES];
    logic             sign_d  [STAGES];
    logic             load    [STAGES];

    always_comb begin
        valid_d[0] = bus.valid_in;
        amt_d[0]   = bus.shift_in;
        mode_d[0]  = mode_e'(bus.mode_in);
        sign_d[0]  = bus.data_in[WIDTH-1];
        data_d[0]  = shift_op(bus.data_in, bus.shift_in & grp_mask(0),
                              mode_e'(bus.mode_in), bus.data_in[WIDTH-1]);
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = valid_q[i-1];
            amt_d[i]   = amt_q[i-1];
            mode_d[i]  = mode_q[i-1];
            sign_d[i]  = sign_q[i-1];
            data_d[i]  = shift_op(data_q[i-1], amt_q[i-1] & grp_mask(i),
                                  mode_q[i-1], sign_q[i-1]);
        end
        // A stage may load when empty or when its successor takes its word.
        load[STAGES-1] = !valid_q[STAGES-1] || bus.ready_out;
        for (int i = STAGES - 2; i >= 0; i--) begin
            load[i] = !valid_q[i] || load[i+1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                amt_q[i]   <= '0;
                mode_q[i]  <= LSL;
                sign_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= valid_d[i];
                    if (valid_d[i]) begin
                        data_q[i] <= data_d[i];
                        amt_q[i]  <= amt_d[i];
                        mode_q[i] <= mode_d[i];
                        sign_q[i] <= sign_d[i];
                    end
                end
            end
        end
    end

    assign bus.ready_in  = load[0] && !reset;
    assign bus.valid_out = valid_q[STAGES-1];
    assign bus.data_out  = data_q[STAGES-1];
endmodule

// File: doc/barrel_shifter_pipelined.md
# barrel_shifter_pipelined

Pipelined, handshaked barrel shifter for the operations library: shifts or rotates a WIDTH-bit word by a per-transaction dynamic amount in one of four modes. Successor to the static shift-left operator, with a run-time shift amount, direction and mode in place of an elaboration-time shift. The amount decode is split across a configurable number of registered stages with valid/ready backpressure, so it can sit on wide datapaths at full clock rate between streaming producers and consumers.

## Interface
- WIDTH, 8, data width; power of two, ≥ 2
- STAGES, 3, register stages; 1 ≤ STAGES ≤ SHIFT_WIDTH
- PAD_VALUE, 1'b0, fill bit for logical shifts
- SHIFT_WIDTH (localparam), $clog2(WIDTH), shift amount width
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all stages
- data_in  input  WIDTH  operand
- shift_in  input  SHIFT_WIDTH  shift amount, 0..WIDTH-1
- mode_in  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
- valid_in  input  1  operand valid
- ready_in  output  1  block accepts operand this cycle
- data_out  output  WIDTH  result
- valid_out  output  1  result valid
- ready_out  input  1  downstream accepts result

## Operation
- Transfer in: valid_in && ready_in on a rising edge. Transfer out: valid_out && ready_out.
- Amount bits are partitioned LSB-first into STAGES groups of G = ceil(SHIFT_WIDTH/STAGES) bits; stage i applies shift bits [i*G, min((i+1)*G, SHIFT_WIDTH)-1].
  - A stage with an empty group passes data through unchanged.
- Each stage registers: valid, partial data, remaining amount bits, mode, and the sign bit captured from data_in[WIDTH-1] at entry.
- Mode rules, amount n:
  - Logical left: vacated LSBs = PAD_VALUE.
  - Logical right: vacated MSBs = PAD_VALUE.
  - Arithmetic right: vacated MSBs = original sign bit.
  - Rotate left: bits leaving the MSB re-enter at the LSB.
  - n = 0 returns data_in unchanged in every mode.
- Per-stage flow control: stage i may load when its valid is 0 or stage i+1 (or ready_out, for the last stage) accepts this cycle. Bubbles collapse.
- ready_in = load condition of stage 0; it depends combinationally on ready_out.
- A stage that holds valid data and is not advancing keeps its contents stable.
- data_out, valid_out and all mode/amount sidebands are driven directly from the last stage's registers.
- Order is strictly preserved; there is no drop and no duplication.

## Timing
- Reset (async assert, sync release at the next edge):
  - All stage valids = 0, all data = 0.
  - valid_out = 0, data_out = 0.
  - ready_in forced to 0 while reset is high.
- Latency = STAGES cycles from input transfer to valid_out, with no backpressure.
- Throughput: one transaction per cycle while ready_out = 1.
- ready_out low with all stages full: ready_in = 0 in the same cycle, and up to STAGES results are held.
- ready_out low with a bubble present: ready_in stays 1 and the bubble is absorbed.
- Simultaneous output and input transfer when full: both occur and the pipeline advances by one.
- Reset asserted mid-operation: in-flight data is discarded and valid_out falls asynchronously. After release, the first accepted input appears STAGES cycles later.
- valid_out never depends combinationally on ready_out.

## Test plan
All scenarios use WIDTH=8 and STAGES=3 unless noted.
- Logical left: data_in=0xB3, shift=3 -> data_out=0x98, valid_out exactly 3 cycles after the transfer.
- Arithmetic right: 0x96, shift=2 -> 0xE5. Logical right with PAD_VALUE=1: 0xF0, shift=4 -> 0xFF. Logical right with PAD_VALUE=0: 0xF0, shift=4 -> 0x0F.
- Rotate left: 0x81, shift=1 -> 0x03. 0x81, shift=7 -> 0xC0. Any value with shift=0 in all four modes -> unchanged.
- Backpressure: stream 0x01..0x08 with shift=1 in mode 00, ready_out=0 for cycles 4..8.
  - ready_in drops once 3 results are held.
  - Outputs are 0x02,0x04,...,0x10 in order, with no loss or duplicates.
  - Each held value stays stable.
- Reset mid-flight: 2 transactions in flight, pulse reset between edges.
  - valid_out=0 and data_out=0 immediately; ready_in=0 during reset.
  - The next input 0x01, shift=2, mode 00 -> 0x04 after 3 cycles.
- Random sweep over WIDTH=8/16/64 and STAGES=1..SHIFT_WIDTH, random modes, random valid_in/ready_out: a scoreboard reference model matches every output in order.
